// File: rtl/buyruk_satir_doldurucu_pkg.sv
// Shared definitions for the instruction-cache line-refill engine:
// FSM state encoding and the default line geometry.
package buyruk_satir_doldurucu_pkg;

   localparam int VARSAYILAN_SATIR_KELIME = 4;
   localparam int VARSAYILAN_KELIME_BIT   = 32;
   localparam int VARSAYILAN_ADRES_BIT    = 32;

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      ISTE  = 2'd1,
      TAMAM = 2'd2
   } durum_t;

endpackage

// File: rtl/buyruk_satir_doldurucu_if.sv
// Bundles the cache-controller request/response and memory read channels
// of the line-refill engine; slave is the engine side, master the environment.
interface buyruk_satir_doldurucu_if import buyruk_satir_doldurucu_pkg::*; #(
   parameter int SATIR_KELIME = VARSAYILAN_SATIR_KELIME,
   parameter int KELIME_BIT   = VARSAYILAN_KELIME_BIT,
   parameter int ADRES_BIT    = VARSAYILAN_ADRES_BIT
) ();

   logic                               istek_gecerli_i;
   logic [ADRES_BIT-1:0]               istek_adres_i;
   logic                               istek_hazir_o;
   logic                               yanit_gecerli_o;
   logic [ADRES_BIT-1:0]               yanit_adres_o;
   logic [SATIR_KELIME*KELIME_BIT-1:0] yanit_satir_o;
   logic                               yanit_hata_o;
   logic                               bellek_istek_gecerli_o;
   logic                               bellek_istek_hazir_i;
   logic [ADRES_BIT-1:0]               bellek_adres_o;
   logic                               bellek_veri_gecerli_i;
   logic [KELIME_BIT-1:0]              bellek_veri_i;
   logic                               bellek_hata_i;

   modport slave (
      input  istek_gecerli_i, istek_adres_i,
      output istek_hazir_o,
      output yanit_gecerli_o, yanit_adres_o, yanit_satir_o, yanit_hata_o,
      output bellek_istek_gecerli_o, bellek_adres_o,
      input  bellek_istek_hazir_i,
      input  bellek_veri_gecerli_i, bellek_veri_i, bellek_hata_i
   );

   modport master (
      output istek_gecerli_i, istek_adres_i,
      input  istek_hazir_o,
      input  yanit_gecerli_o, yanit_adres_o, yanit_satir_o, yanit_hata_o,
      input  bellek_istek_gecerli_o, bellek_adres_o,
      output bellek_istek_hazir_i,
      output bellek_veri_gecerli_i, bellek_veri_i, bellek_hata_i
   );

endinterface

// File: rtl/buyruk_satir_doldurucu.sv
// Instruction-cache line-refill engine: issues critical-word-first word reads,
// assembles the returned words into a line and returns it in a one-cycle response.
module buyruk_satir_doldurucu import buyruk_satir_doldurucu_pkg::*; #(
   parameter int SATIR_KELIME = VARSAYILAN_SATIR_KELIME,
   parameter int KELIME_BIT   = VARSAYILAN_KELIME_BIT,
   parameter int ADRES_BIT    = VARSAYILAN_ADRES_BIT
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   buyruk_satir_doldurucu_if.slave bus
);

   localparam int IW = $clog2(SATIR_KELIME);
   localparam int CW = IW + 1;
   localparam logic [CW-1:0]        SON       = CW'(SATIR_KELIME);
   localparam logic [CW-1:0]        SON_EKSI  = CW'(SATIR_KELIME - 1);
   localparam logic [ADRES_BIT-1:0] SATIR_MASKE = ADRES_BIT'(SATIR_KELIME * 4 - 1);

   durum_t                                durum, sonraki_durum;
   logic [ADRES_BIT-1:0]                  taban;
   logic [IW-1:0]                         baslangic;
   logic [CW-1:0]                         iste_say, al_say;
   logic                                  hata;
   logic [SATIR_KELIME-1:0][KELIME_BIT-1:0] satir;

   logic          kabul, iste_el, veri_al;
   logic [IW-1:0] iste_yuva, al_yuva;

   assign kabul   = (durum == BOSTA) && bus.istek_gecerli_i;
   assign iste_el = (durum == ISTE) && (iste_say < SON) && bus.bellek_istek_hazir_i;
   assign veri_al = (durum == ISTE) && (al_say < SON) && bus.bellek_veri_gecerli_i;

   // Slot arithmetic is IW bits wide so the fetch order wraps within the line.
   assign iste_yuva = baslangic + iste_say[IW-1:0];
   assign al_yuva   = baslangic + al_say[IW-1:0];

   // NOTE: registers are updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_i) durum <= BOSTA;
      else        durum <= sonraki_durum;
   end

   // NOTE: default assignment first so no path leaves the variable unassigned (no latch).
   always_comb begin
      sonraki_durum = durum;
      unique case (durum)
         BOSTA:   if (bus.istek_gecerli_i) sonraki_durum = ISTE;
         ISTE:    if (veri_al && (al_say == SON_EKSI)) sonraki_durum = TAMAM;
         TAMAM:   sonraki_durum = BOSTA;
         default: sonraki_durum = BOSTA;
      endcase
   end

   // NOTE: the line register is reset as well, so it never presents stale content.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         taban     <= '0;
         baslangic <= '0;
         iste_say  <= '0;
         al_say    <= '0;
         hata      <= 1'b0;
         satir     <= '0;
      end else if (kabul) begin
         taban     <= bus.istek_adres_i & ~SATIR_MASKE;
         baslangic <= bus.istek_adres_i[IW+1:2];
         iste_say  <= '0;
         al_say    <= '0;
         hata      <= 1'b0;
      end else begin
         if (iste_el) iste_say <= iste_say + CW'(1);
         if (veri_al) begin
            satir[al_yuva] <= bus.bellek_veri_i;
            hata           <= hata | bus.bellek_hata_i;
            al_say         <= al_say + CW'(1);
         end
      end
   end

   // Every output is forced low while reset is held, including the ready flag.
   always_comb begin
      bus.istek_hazir_o          = 1'b0;
      bus.bellek_istek_gecerli_o = 1'b0;
      bus.bellek_adres_o         = '0;
      bus.yanit_gecerli_o        = 1'b0;
      bus.yanit_adres_o          = '0;
      bus.yanit_satir_o          = '0;
      bus.yanit_hata_o           = 1'b0;
      if (rst_i) begin
         bus.istek_hazir_o          = (durum == BOSTA);
         bus.bellek_istek_gecerli_o = (durum == ISTE) && (iste_say < SON);
         bus.bellek_adres_o         = taban | (ADRES_BIT'(iste_yuva) << 2);
         bus.yanit_gecerli_o        = (durum == TAMAM);
         bus.yanit_adres_o          = taban;
         bus.yanit_satir_o          = satir;
         bus.yanit_hata_o           = hata;
      end
   end

endmodule

// File: doc/buyruk_satir_doldurucu.md
# buyruk_satir_doldurucu

Line-refill engine directly downstream of `buyruk_onbellegi_denetleyici`. On an instruction-cache miss it accepts one line-fill request and issues the individual word reads to the memory bus, critical word first. It assembles the returned words into a full cache line and hands the line back to the cache controller in a single-cycle response. Only one fill is in flight at a time; memory word reads may be pipelined.

## Interface
- `SATIR_KELIME`, 4, words per cache line; power of two, ≥2
- `KELIME_BIT`, 32, word width
- `ADRES_BIT`, 32, byte-address width
- `clk_i` in 1 — single clock, rising edge
- `rst_i` in 1 — synchronous, active-low reset
- `istek_gecerli_i` in 1 — fill request valid, from cache controller
- `istek_adres_i` in ADRES_BIT — miss byte address; any alignment within the line
- `istek_hazir_o` out 1 — block can accept a request
- `yanit_gecerli_o` out 1 — one-cycle pulse: line complete
- `yanit_adres_o` out ADRES_BIT — line base address
- `yanit_satir_o` out SATIR_KELIME*KELIME_BIT — line; word k in bits [k*KELIME_BIT +: KELIME_BIT]
- `yanit_hata_o` out 1 — at least one word returned a bus error
- `bellek_istek_gecerli_o` out 1 — memory read request valid
- `bellek_istek_hazir_i` in 1 — memory accepts the request
- `bellek_adres_o` out ADRES_BIT — word-aligned read address
- `bellek_veri_gecerli_i` in 1 — read data valid; returned in request order
- `bellek_veri_i` in KELIME_BIT — read data
- `bellek_hata_i` in 1 — bus error; qualified by `bellek_veri_gecerli_i`

## Operation
- Line offset bits: L = log2(SATIR_KELIME)+2.
- Line base address: `istek_adres_i` with the low L bits cleared.
- Start index: s = `istek_adres_i`[L-1:2].
- States:
  - BOSTA: `istek_hazir_o`=1. Request accepted on `istek_gecerli_i` & `istek_hazir_o`. On accept, latch base and s, clear issue counter, receive counter and error flag, then go to ISTE.
  - ISTE (issue and collect): `bellek_istek_gecerli_o`=1 while issue counter < SATIR_KELIME.
    - `bellek_adres_o` = base + 4·((s+issue counter) mod SATIR_KELIME), so the fetch order wraps within the line.
    - Issue counter advances on each handshake.
    - Each `bellek_veri_gecerli_i` stores `bellek_veri_i` into slot (s+receive counter) mod SATIR_KELIME, ORs `bellek_hata_i` into the error flag and advances the receive counter.
    - After the last word is stored, go to TAMAM.
  - TAMAM: `yanit_gecerli_o`=1 for exactly one cycle with line, base and error flag, then return to BOSTA. The cache controller never back-pressures.
- A bus error does not abort the fill. All SATIR_KELIME words are still collected; `yanit_hata_o`=1.
- `bellek_veri_gecerli_i` outside ISTE, or once the receive counter equals SATIR_KELIME, is ignored.
- Request and data handshakes in the same cycle are both processed.
- Counters are log2(SATIR_KELIME)+1 bits wide; slot indexing wraps modulo SATIR_KELIME.

## Timing
- Reset (`rst_i`=0 at a rising edge): state BOSTA; counters, error flag and line register cleared. While `rst_i`=0, all outputs are 0, including `istek_hazir_o`.
- `istek_hazir_o`=1 from the first cycle after reset is released.
- Reset mid-fill drops the fill with no response. The memory side shares `rst_i`, so no stale data follows.
- Accept at cycle 0 → first `bellek_istek_gecerli_o` at cycle 1.
- Memory latency ≥1 cycle after request handshake.
- Last word stored at cycle M → `yanit_gecerli_o` at M+1 → `istek_hazir_o`=1 at M+2.
- Best case (memory always ready, 1-cycle data): requests at cycles 1–4, data at 2–5, response at 6, next accept at 7.
- `bellek_adres_o` and `bellek_istek_gecerli_o` hold stable while `bellek_istek_hazir_i`=0.
- `yanit_*` is valid only with `yanit_gecerli_o`.

## Structure
- State encodings (BOSTA, ISTE, TAMAM) and the default SATIR_KELIME go in `tanimlamalar.vh`.
- Single module; no sub-module. The address and slot generation is a few lines inline.

## Test plan
- Aligned fill, `istek_adres_i`=0x0000_1000, memory always ready, data = address → addresses 0x1000, 0x1004, 0x1008, 0x100C; response at cycle 6 with line {0x100C, 0x1008, 0x1004, 0x1000}, `yanit_adres_o`=0x1000, `yanit_hata_o`=0.
- Critical-word-first, `istek_adres_i`=0x0000_2008 → addresses 0x2008, 0x200C, 0x2000, 0x2004; each word lands in its correct slot; `yanit_adres_o`=0x2000.
- Back-pressure: `bellek_istek_hazir_i` low for 3 cycles on word 1 → address held stable; response at cycle 9; no duplicate request.
- Bus error: `bellek_hata_i`=1 on the second returned word → all 4 words still collected; `yanit_hata_o`=1 with `yanit_gecerli_o`.
- Reset mid-fill after 2 words returned → `istek_hazir_o`=0 during reset and 1 the cycle after; no `yanit_gecerli_o`; a new request to 0x3000 then completes correctly.
- Spurious `bellek_veri_gecerli_i` while in BOSTA → ignored; the next fill's line is unaffected.
